// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage: widths, FSM state
// encoding and the MEM/WB bundle that feeds write-back and forwarding.
package mem_stage_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 4;
    localparam int CNT_W   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic               reg_write_en;
        logic [RADDR_W-1:0] reg_write_addr;
        logic [DATA_W-1:0]  data;
    } mem_wb_t;

    function automatic mem_wb_t wb_pack(
        input logic               en,
        input logic [RADDR_W-1:0] addr,
        input logic [DATA_W-1:0]  data
    );
        mem_wb_t w;
        w.reg_write_en   = en;
        w.reg_write_addr = addr;
        w.data           = data;
        return w;
    endfunction

    // A store wins over a load when both bits are set, so only a pure load
    // returns memory data.
    function automatic logic [DATA_W-1:0] wb_result(
        input logic              is_store,
        input logic              is_load,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] rdata
    );
        logic [DATA_W-1:0] r;
        if (is_load && !is_store) begin
            r = rdata;
        end else begin
            r = alu;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the write enable so the
// destination and data fields keep their previous contents.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_bubble,
    input  mem_wb_t i_d,
    output mem_wb_t o_q
);

    mem_wb_t r_q;

    // MEM/WB bundle register with bubble insertion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_bubble) begin
            r_q.reg_write_en <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory req/ack bus, stalls the front
// of the pipeline while an access is outstanding, and times out lost acks.
module mem_stage #(
    parameter int DATA_W      = 16,
    parameter int RADDR_W     = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               reg_write_en_i,
    input  logic               mem_write_en_i,
    input  logic               mem_to_reg_i,
    input  logic [DATA_W-1:0]  alu_i,
    input  logic [DATA_W-1:0]  reg_data2_i,
    input  logic [RADDR_W-1:0] reg_write_addr_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [DATA_W-1:0]  dmem_addr_o,
    output logic [DATA_W-1:0]  dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [DATA_W-1:0]  dmem_rdata_i,
    output logic               stall_o,
    output logic               wb_reg_write_en_o,
    output logic [RADDR_W-1:0] wb_reg_write_addr_o,
    output logic [DATA_W-1:0]  wb_data_o,
    output logic               err_o
);

    import mem_stage_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;

    logic               r_hold_we;
    logic               r_hold_m2r;
    logic               r_hold_rwe;
    logic [DATA_W-1:0]  r_hold_addr;
    logic [DATA_W-1:0]  r_hold_wdata;
    logic [RADDR_W-1:0] r_hold_waddr;
    logic               w_hold_load;

    logic               w_access;
    logic               w_req;
    logic               w_we;
    logic [DATA_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_stall;
    logic               w_bubble;
    mem_wb_t            w_wb_d;
    mem_wb_t            w_wb_q;

    assign w_access = mem_write_en_i | mem_to_reg_i;

    // Next-state, bus drive, stall and MEM/WB input selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_hold_load = 1'b0;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_wb_d      = wb_pack(reg_write_en_i, reg_write_addr_i, alu_i);
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_req   = 1'b1;
                    w_we    = mem_write_en_i;
                    w_addr  = alu_i;
                    w_wdata = reg_data2_i;
                    if (dmem_ack_i) begin
                        w_wb_d = wb_pack(reg_write_en_i, reg_write_addr_i,
                                         wb_result(mem_write_en_i, mem_to_reg_i,
                                                   alu_i, dmem_rdata_i));
                    end else begin
                        w_stall     = 1'b1;
                        w_bubble    = 1'b1;
                        w_hold_load = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = WAIT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                // EX/MEM is frozen but not trusted here; everything comes from hold
                w_req   = 1'b1;
                w_we    = r_hold_we;
                w_addr  = r_hold_addr;
                w_wdata = r_hold_wdata;
                w_wb_d  = wb_pack(r_hold_rwe, r_hold_waddr,
                                  wb_result(r_hold_we, r_hold_m2r,
                                            r_hold_addr, dmem_rdata_i));
                if (dmem_ack_i) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_bubble    = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall     = 1'b1;
                    w_bubble    = 1'b1;
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, wait counter and timeout error pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Request hold registers, captured when an access first misses its ack
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_we    <= 1'b0;
            r_hold_m2r   <= 1'b0;
            r_hold_rwe   <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
            r_hold_waddr <= '0;
        end else if (w_hold_load) begin
            r_hold_we    <= mem_write_en_i;
            r_hold_m2r   <= mem_to_reg_i;
            r_hold_rwe   <= reg_write_en_i;
            r_hold_addr  <= alu_i;
            r_hold_wdata <= reg_data2_i;
            r_hold_waddr <= reg_write_addr_i;
        end else begin
            r_hold_we    <= r_hold_we;
            r_hold_m2r   <= r_hold_m2r;
            r_hold_rwe   <= r_hold_rwe;
            r_hold_addr  <= r_hold_addr;
            r_hold_wdata <= r_hold_wdata;
            r_hold_waddr <= r_hold_waddr;
        end
    end

    mem_wb_reg u_mem_wb (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_bubble (w_bubble),
        .i_d      (w_wb_d),
        .o_q      (w_wb_q)
    );

    // Bus and stall are gated by reset so nothing leaks out while it is held
    assign dmem_req_o   = w_req & rst_ni;
    assign dmem_we_o    = w_we & rst_ni;
    assign dmem_addr_o  = rst_ni ? w_addr : '0;
    assign dmem_wdata_o = rst_ni ? w_wdata : '0;
    assign stall_o      = w_stall & rst_ni;

    assign wb_reg_write_en_o   = w_wb_q.reg_write_en;
    assign wb_reg_write_addr_o = w_wb_q.reg_write_addr;
    assign wb_data_o           = w_wb_q.data;
    assign err_o               = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-built
// multi-cycle sequences for ack delay, timeout and mid-access reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        reg_write_en_i;
    logic        mem_write_en_i;
    logic        mem_to_reg_i;
    logic [15:0] alu_i;
    logic [15:0] reg_data2_i;
    logic [3:0]  reg_write_addr_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [15:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [15:0] dmem_rdata_i;
    logic        stall_o;
    logic        wb_reg_write_en_o;
    logic [3:0]  wb_reg_write_addr_o;
    logic [15:0] wb_data_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    mem_stage #(.DATA_W(16), .RADDR_W(4), .ACK_TIMEOUT(8)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .reg_write_en_i      (reg_write_en_i),
        .mem_write_en_i      (mem_write_en_i),
        .mem_to_reg_i        (mem_to_reg_i),
        .alu_i               (alu_i),
        .reg_data2_i         (reg_data2_i),
        .reg_write_addr_i    (reg_write_addr_i),
        .dmem_req_o          (dmem_req_o),
        .dmem_we_o           (dmem_we_o),
        .dmem_addr_o         (dmem_addr_o),
        .dmem_wdata_o        (dmem_wdata_o),
        .dmem_ack_i          (dmem_ack_i),
        .dmem_rdata_i        (dmem_rdata_i),
        .stall_o             (stall_o),
        .wb_reg_write_en_o   (wb_reg_write_en_o),
        .wb_reg_write_addr_o (wb_reg_write_addr_o),
        .wb_data_o           (wb_data_o),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rwe;
        logic        mwe;
        logic        m2r;
        logic [15:0] alu;
        logic [15:0] d2;
        logic [3:0]  waddr;
        logic        ack;
        logic [15:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_stall;
        logic        e_wb_en;
        logic [3:0]  e_wb_addr;
        logic [15:0] e_wb_data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        reg_write_en_i = 1'b0;
        mem_write_en_i = 1'b0;
        mem_to_reg_i   = 1'b0;
        dmem_ack_i     = 1'b0;
    endtask

    // One access from IDLE; EX/MEM fields are scrambled while stalled so the
    // hold path is exercised. ack_at < 0 means the ack never arrives.
    task automatic run_access(input logic st, input logic [15:0] a, input logic [15:0] wd,
                              input logic [3:0] wa, input logic rwe, input int ack_at,
                              input logic [15:0] rd, input int ncyc,
                              output int nreq, output int nstall, output int nerr,
                              output int nwr, output logic [15:0] last_data,
                              output logic last_en);
        logic active;
        nreq = 0; nstall = 0; nerr = 0; nwr = 0;
        last_data = 16'h0000; last_en = 1'b0;
        @(negedge clk);
        mem_write_en_i   = st;
        mem_to_reg_i     = !st;
        alu_i            = a;
        reg_data2_i      = wd;
        reg_write_addr_i = wa;
        reg_write_en_i   = rwe;
        dmem_rdata_i     = rd;
        dmem_ack_i       = 1'b0;
        active           = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0 && active) begin
                alu_i            = ~a;
                reg_data2_i      = ~wd;
                reg_write_addr_i = ~wa;
            end
            dmem_ack_i = (c == ack_at);
            #1;
            if (dmem_req_o) nreq++;
            if (stall_o) nstall++;
            if (active) begin
                chk("hold_req", 32'(dmem_req_o), 32'h1);
                chk("hold_we", 32'(dmem_we_o), 32'(st));
                chk("hold_addr", 32'(dmem_addr_o), 32'(a));
                if (st) chk("hold_wdata", 32'(dmem_wdata_o), 32'(wd));
                if (!stall_o) begin
                    active = 1'b0;
                    set_nop();
                    dmem_ack_i = (c == ack_at);
                end
            end
            @(posedge clk);
            #1;
            if (wb_reg_write_en_o) nwr++;
            if (err_o) nerr++;
            if (c == ack_at) begin
                last_data = wb_data_o;
                last_en   = wb_reg_write_en_o;
            end
            dmem_ack_i = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int nreq, nstall, nerr, nwr;
        logic [15:0] ld;
        logic le;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd5,  1'b0, 16'h0000,
                    1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd5,  16'h1234};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 4'd3,  1'b1, 16'hBEEF,
                    1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 4'd3,  16'hBEEF};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h5A5A, 4'd7,  1'b1, 16'hFFFF,
                    1'b1, 1'b1, 16'h0020, 16'h5A5A, 1'b0, 1'b0, 4'd7,  16'h0020};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0031, 16'h1111, 4'd9,  1'b1, 16'h2222,
                    1'b1, 1'b1, 16'h0031, 16'h1111, 1'b0, 1'b1, 4'd9,  16'h0031};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 4'd2,  1'b1, 16'hDEAD,
                    1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd2,  16'h00FF};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 4'd15, 1'b0, 16'h0000,
                    1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd15, 16'hFFFF};

        // Reset with a load presented: bus must stay quiet
        rst_ni = 1'b0;
        set_nop();
        mem_to_reg_i     = 1'b1;
        alu_i            = 16'h1234;
        reg_data2_i      = 16'h0000;
        reg_write_addr_i = 4'd0;
        dmem_rdata_i     = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_addr", 32'(dmem_addr_o), 32'h0);
        chk("rst_wb_en", 32'(wb_reg_write_en_o), 32'h0);
        chk("rst_wb_addr", 32'(wb_reg_write_addr_o), 32'h0);
        chk("rst_wb_data", 32'(wb_data_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        @(negedge clk);
        set_nop();
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            reg_write_en_i   = vecs[i].rwe;
            mem_write_en_i   = vecs[i].mwe;
            mem_to_reg_i     = vecs[i].m2r;
            alu_i            = vecs[i].alu;
            reg_data2_i      = vecs[i].d2;
            reg_write_addr_i = vecs[i].waddr;
            dmem_ack_i       = vecs[i].ack;
            dmem_rdata_i     = vecs[i].rdata;
            #1;
            chk("vec_req", 32'(dmem_req_o), 32'(vecs[i].e_req));
            chk("vec_stall", 32'(stall_o), 32'(vecs[i].e_stall));
            if (vecs[i].e_req) begin
                chk("vec_we", 32'(dmem_we_o), 32'(vecs[i].e_we));
                chk("vec_addr", 32'(dmem_addr_o), 32'(vecs[i].e_addr));
                if (vecs[i].e_we) chk("vec_wdata", 32'(dmem_wdata_o), 32'(vecs[i].e_wdata));
            end
            @(posedge clk);
            #1;
            chk("vec_wb_en", 32'(wb_reg_write_en_o), 32'(vecs[i].e_wb_en));
            chk("vec_wb_addr", 32'(wb_reg_write_addr_o), 32'(vecs[i].e_wb_addr));
            chk("vec_wb_data", 32'(wb_data_o), 32'(vecs[i].e_wb_data));
            chk("vec_err", 32'(err_o), 32'h0);
        end
        @(negedge clk);
        set_nop();

        // Store, ack three cycles after the first request cycle
        run_access(1'b1, 16'h0010, 16'hA5A5, 4'd4, 1'b0, 3, 16'h0000, 8,
                   nreq, nstall, nerr, nwr, ld, le);
        chk("st3_req_cycles", nreq, 4);
        chk("st3_stall_cycles", nstall, 3);
        chk("st3_err", nerr, 0);
        chk("st3_writes", nwr, 0);
        chk("st3_wb_data", 32'(ld), 32'h0010);

        // Load, ack two cycles late
        run_access(1'b0, 16'h0077, 16'h0000, 4'd6, 1'b1, 2, 16'hC0DE, 6,
                   nreq, nstall, nerr, nwr, ld, le);
        chk("ld2_req_cycles", nreq, 3);
        chk("ld2_stall_cycles", nstall, 2);
        chk("ld2_writes", nwr, 1);
        chk("ld2_wb_en", 32'(le), 32'h1);
        chk("ld2_wb_data", 32'(ld), 32'hC0DE);

        // No ack at all: timeout
        run_access(1'b0, 16'h0080, 16'h0000, 4'd2, 1'b1, -1, 16'h0000, 14,
                   nreq, nstall, nerr, nwr, ld, le);
        chk("to_req_cycles", nreq, 9);
        chk("to_stall_cycles", nstall, 8);
        chk("to_err_pulses", nerr, 1);
        chk("to_writes", nwr, 0);

        // Ack on the timeout cycle wins
        run_access(1'b0, 16'h0081, 16'h0000, 4'd3, 1'b1, 8, 16'h5555, 14,
                   nreq, nstall, nerr, nwr, ld, le);
        chk("ack9_req_cycles", nreq, 9);
        chk("ack9_stall_cycles", nstall, 8);
        chk("ack9_err_pulses", nerr, 0);
        chk("ack9_writes", nwr, 1);
        chk("ack9_wb_data", 32'(ld), 32'h5555);

        // Reset asserted while waiting for an ack
        @(negedge clk);
        mem_to_reg_i     = 1'b1;
        reg_write_en_i   = 1'b1;
        alu_i            = 16'h0099;
        reg_write_addr_i = 4'd11;
        dmem_ack_i       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("wrst_pre_stall", 32'(stall_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("wrst_req", 32'(dmem_req_o), 32'h0);
        chk("wrst_stall", 32'(stall_o), 32'h0);
        chk("wrst_we", 32'(dmem_we_o), 32'h0);
        chk("wrst_addr", 32'(dmem_addr_o), 32'h0);
        chk("wrst_wb_en", 32'(wb_reg_write_en_o), 32'h0);
        chk("wrst_wb_addr", 32'(wb_reg_write_addr_o), 32'h0);
        chk("wrst_wb_data", 32'(wb_data_o), 32'h0);
        chk("wrst_err", 32'(err_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_ni           = 1'b1;
        alu_i            = 16'h0040;
        reg_write_addr_i = 4'd8;
        dmem_rdata_i     = 16'h1357;
        dmem_ack_i       = 1'b1;
        #1;
        chk("post_req", 32'(dmem_req_o), 32'h1);
        chk("post_addr", 32'(dmem_addr_o), 32'h0040);
        chk("post_stall", 32'(stall_o), 32'h0);
        @(posedge clk);
        #1;
        chk("post_wb_en", 32'(wb_reg_write_en_o), 32'h1);
        chk("post_wb_addr", 32'(wb_reg_write_addr_o), 32'h8);
        chk("post_wb_data", 32'(wb_data_o), 32'h1357);
        chk("post_err", 32'(err_o), 32'h0);
        @(negedge clk);
        set_nop();
        @(posedge clk);
        #1;
        chk("post_err2", 32'(err_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM control and data fields and runs loads and stores on the data-memory bus using a req/ack handshake. While the access is outstanding it stalls the front of the pipeline and enforces an ack timeout. It registers the write-back result into the MEM/WB fields that feed register-file write-back and forwarding.

## Interface
Parameters:
- DATA_W, 16, datapath, memory-address and memory-data width
- RADDR_W, 4, register-file address width
- ACK_TIMEOUT, 8, maximum WAIT cycles before an access is abandoned (legal range 1..255)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- reg_write_en_i  in  1  EX/MEM: instruction writes the register file
- mem_write_en_i  in  1  EX/MEM: store
- mem_to_reg_i  in  1  EX/MEM: load; write-back data comes from memory
- alu_i  in  DATA_W  EX/MEM: ALU result; memory word address for loads and stores
- reg_data2_i  in  DATA_W  EX/MEM: store data
- reg_write_addr_i  in  RADDR_W  EX/MEM: destination register
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write, 0 = read
- dmem_addr_o  out  DATA_W  word address
- dmem_wdata_o  out  DATA_W  write data
- dmem_ack_i  in  1  memory completes the request this cycle; dmem_rdata_i is valid in the same cycle
- dmem_rdata_i  in  DATA_W  read data
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- wb_reg_write_en_o  out  1  MEM/WB: register write enable
- wb_reg_write_addr_o  out  RADDR_W  MEM/WB: destination register
- wb_data_o  out  DATA_W  MEM/WB: write-back data
- err_o  out  1  one-cycle pulse when an access times out

## Operation
- access = mem_write_en_i | mem_to_reg_i. If both bits are set, the access is a store (mem_write_en_i wins) and the write-back data is the ALU result.
- FSM states: IDLE and WAIT.
- IDLE, no access: MEM/WB loads {reg_write_en_i, reg_write_addr_i, alu_i}. stall_o = 0.
- IDLE, access:
  - dmem_req_o = 1. dmem_we_o, dmem_addr_o and dmem_wdata_o are driven combinationally from the inputs.
  - If dmem_ack_i = 1, the access completes this cycle. There is no stall. MEM/WB loads the result: wb_data_o = dmem_rdata_i for a load, alu_i otherwise.
  - If dmem_ack_i = 0: stall_o = 1. The request fields and control bits are latched into hold registers. The FSM moves to WAIT with wait counter cnt = 0. MEM/WB loads a bubble: wb_reg_write_en_o = 0, and wb_reg_write_addr_o and wb_data_o keep their previous values.
- WAIT:
  - dmem_req_o = 1. The request fields come from the hold registers and are stable until ack or timeout.
  - Ack: MEM/WB loads the result from the hold registers and dmem_rdata_i. stall_o = 0. Next state is IDLE.
  - No ack and cnt = ACK_TIMEOUT-1: this is the timeout cycle. stall_o = 0. MEM/WB loads a bubble. Next state is IDLE. err_o = 1 in the following cycle. The instruction is dropped.
  - Otherwise: stall_o = 1, MEM/WB loads a bubble, and cnt increments.
- Ack and timeout in the same cycle: the ack wins and no error is raised.
- dmem_ack_i while dmem_req_o = 0 is ignored.
- Upstream holds the EX/MEM fields while stall_o = 1. This block never reads them in WAIT.

## Timing
- Non-memory instruction: 1-cycle latency, EX/MEM to MEM/WB.
- Access with same-cycle ack: 1-cycle latency, no stall.
- Ack k cycles after the first request cycle (1 ≤ k ≤ ACK_TIMEOUT): stall_o is high for k cycles, and the result appears in MEM/WB at the edge ending the ack cycle.
- Timeout: dmem_req_o is high for exactly 1 + ACK_TIMEOUT cycles, and stall_o is high for ACK_TIMEOUT of them.
- stall_o, dmem_req_o, dmem_we_o, dmem_addr_o and dmem_wdata_o are combinational from state, inputs and dmem_ack_i. All wb_* outputs and err_o are registered.
- Reset (rst_ni = 0, at any time, including mid-access):
  - Immediately: state IDLE, cnt 0, hold registers 0, every wb_* output 0, err_o 0.
  - dmem_req_o, dmem_we_o and stall_o are forced to 0 while reset is asserted. dmem_addr_o and dmem_wdata_o are 0.
  - An in-flight access is abandoned without err_o.

## Structure
- The shared package holds DATA_W, RADDR_W, the state typedef {IDLE, WAIT} and the MEM/WB bundle struct {reg_write_en, reg_write_addr, data}.
- One sub-module, mem_wb_reg: an async-active-low-reset register for the MEM/WB bundle with a bubble input that clears reg_write_en.
- The FSM, wait counter, hold registers and result mux stay in mem_stage.

## Test plan
- ALU op: alu_i = 0x1234, reg_write_addr_i = 5, reg_write_en_i = 1 → next cycle wb_reg_write_en_o = 1, wb_reg_write_addr_o = 5, wb_data_o = 0x1234, and stall_o stays 0.
- Load with same-cycle ack: alu_i = 0x0040, dmem_rdata_i = 0xBEEF, ack in the request cycle → dmem_addr_o = 0x0040, dmem_we_o = 0, no stall, and next cycle wb_data_o = 0xBEEF.
- Store with 3-cycle ack delay: alu_i = 0x0010, reg_data2_i = 0xA5A5 → dmem_we_o = 1 and dmem_wdata_o = 0xA5A5 are held for 4 cycles, stall_o is high for 3 cycles, and wb_reg_write_en_o = 0 throughout (store).
- Timeout with ACK_TIMEOUT = 8 and no ack → dmem_req_o is high for 9 cycles, stall_o is high for 8, err_o pulses once, and no register write occurs. An ack arriving on the 9th cycle instead → normal completion, err_o = 0.
- Reset pulse during WAIT → dmem_req_o and stall_o drop immediately, and all outputs are 0. The next load after reset release completes normally.
